three_digit_sseg_mux: RTL and testbench

- Downstream consumer of the three-digit BCD incrementer: captures its 12-bit BCD result and overflow flag, then drives a time-multiplexed 3-digit active-low seven-segment display.
- Contains a refresh prescaler, a digit scan state machine, a snapshot register and a registered segment decoder.
- Lets board tops show the incrementer output without combinational glitches on the LED pins.

---
 rtl/sseg_pkg.sv | 30 +++
 rtl/bcd_to_sseg.sv | 27 ++
 rtl/three_digit_sseg_mux.sv | 135 +++++++++++++
 tb/tb_three_digit_sseg_mux.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared types and constants for the three-digit seven-segment display mux.
// All segment and anode patterns are active-low.
package sseg_pkg;

   typedef enum logic [1:0] {
      DIG0 = 2'd0,
      DIG1 = 2'd1,
      DIG2 = 2'd2
   } scan_state_t;

   // Segment order is [6:0] = g..a
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [2:0] AN_OFF  = 3'b111;
   localparam logic [2:0] AN_DIG0 = 3'b110;
   localparam logic [2:0] AN_DIG1 = 3'b101;
   localparam logic [2:0] AN_DIG2 = 3'b011;

endpackage

// File: rtl/bcd_to_sseg.sv
// Combinational BCD nibble to active-low seven-segment decoder.
// Non-decimal nibbles (A-F) render as a dash.
module bcd_to_sseg
   import sseg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (nibble)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/three_digit_sseg_mux.sv
// Snapshots a 3-digit BCD value plus overflow and scans it onto a multiplexed
// active-low display with glitch-free registered outputs.
// Optional macro SSEG_LEADING_ZERO_BLANK_EN blanks leading zeros in hundreds/tens.
//
// state | meaning
// ------+--------------------------------------------
// DIG0  | ones digit lit (an[0]), decodes snap[3:0]
// DIG1  | tens digit lit (an[1]), decodes snap[7:4]
// DIG2  | hundreds digit lit (an[2]), decodes snap[11:8]; dp shows overflow
module three_digit_sseg_mux
   import sseg_pkg::*;
#(
   parameter int REFRESH_COUNT = 100000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [11:0] bcd,
   input  logic        ovf,
   input  logic        load,
   input  logic        disp_en,
   output logic [2:0]  an,
   output logic [7:0]  sseg
);

   localparam int CNT_W = $clog2(REFRESH_COUNT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_COUNT - 1);

   logic [CNT_W-1:0] tick_cnt;
   logic             advance;
   logic [11:0]      snap;
   logic             ovf_q;
   scan_state_t      state_q;
   scan_state_t      state_d;
   logic [3:0]       digit_nib;
   logic [2:0]       an_sel;
   logic [6:0]       seg_raw;
   logic [6:0]       seg_digit;
   logic             blank;
   logic             dp_n;

   assign advance = (tick_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tick_cnt <= '0;
      end else if (advance) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         snap  <= 12'h000;
         ovf_q <= 1'b0;
      end else if (load) begin
         snap  <= bcd;
         ovf_q <= ovf;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= DIG0;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (advance) begin
         case (state_q)
            DIG0:    state_d = DIG1;
            DIG1:    state_d = DIG2;
            DIG2:    state_d = DIG0;
            default: state_d = DIG0;
         endcase
      end
   end

   always_comb begin
      digit_nib = snap[3:0];
      an_sel    = AN_DIG0;
      case (state_q)
         DIG0: begin
            digit_nib = snap[3:0];
            an_sel    = AN_DIG0;
         end
         DIG1: begin
            digit_nib = snap[7:4];
            an_sel    = AN_DIG1;
         end
         DIG2: begin
            digit_nib = snap[11:8];
            an_sel    = AN_DIG2;
         end
         default: begin
            digit_nib = snap[3:0];
            an_sel    = AN_DIG0;
         end
      endcase
   end

   bcd_to_sseg u_dec (
      .nibble (digit_nib),
      .seg    (seg_raw)
   );

`ifdef SSEG_LEADING_ZERO_BLANK_EN
   // Ones digit is never blanked so a zero value still shows "0"
   assign blank = ((state_q == DIG2) && (snap[11:8] == 4'h0)) ||
                  ((state_q == DIG1) && (snap[11:4] == 8'h00));
`else
   assign blank = 1'b0;
`endif

   assign seg_digit = blank ? SEG_BLANK : seg_raw;
   assign dp_n      = !((state_q == DIG2) && ovf_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         an   <= AN_OFF;
         sseg <= 8'hFF;
      end else if (disp_en) begin
         an   <= an_sel;
         sseg <= {dp_n, seg_digit};
      end else begin
         an   <= AN_OFF;
         sseg <= 8'hFF;
      end
   end

endmodule

// File: tb/tb_three_digit_sseg_mux.sv
// Scoreboard bench for three_digit_sseg_mux: a time-based display model feeds an
// expectation queue; a separate monitor compares every registered output cycle.
module tb_three_digit_sseg_mux;

   localparam int RC = 4;
   localparam logic [6:0] SEG_TAB [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   logic        clk;
   logic        reset_n;
   logic [11:0] bcd;
   logic        ovf;
   logic        load;
   logic        disp_en;
   logic [2:0]  an;
   logic [7:0]  sseg;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: edges counted since reset release give the scan position directly
   int          edges = 0;
   logic [11:0] snap_m = 12'h000;
   logic        ovf_m = 1'b0;
   logic [10:0] exp_q [$];

   three_digit_sseg_mux #(.REFRESH_COUNT(RC)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bcd     (bcd),
      .ovf     (ovf),
      .load    (load),
      .disp_en (disp_en),
      .an      (an),
      .sseg    (sseg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Drive inputs for the coming edge and queue what that edge must produce
   task automatic apply(input logic l, input logic [11:0] b, input logic o, input logic e);
      int          d;
      logic [3:0]  nib;
      logic [6:0]  g;
      logic [2:0]  an_e;
      load = l; bcd = b; ovf = o; disp_en = e;
      d   = (edges / RC) % 3;
      nib = 4'((snap_m >> (4 * d)) & 12'hF);
      g   = (nib > 4'd9) ? 7'b0111111 : SEG_TAB[int'(nib)];
`ifdef SSEG_LEADING_ZERO_BLANK_EN
      if (d == 2 && snap_m[11:8] == 4'h0) g = 7'b1111111;
      if (d == 1 && snap_m[11:4] == 8'h00) g = 7'b1111111;
`endif
      an_e = 3'b111;
      an_e[d] = 1'b0;
      if (e) exp_q.push_back({an_e, !(d == 2 && ovf_m), g});
      else   exp_q.push_back({3'b111, 8'hFF});
      if (l) begin
         snap_m = b;
         ovf_m  = o;
      end
      edges++;
   endtask

   task automatic step(input logic l, input logic [11:0] b, input logic o, input logic e);
      @(negedge clk);
      apply(l, b, o, e);
   endtask

   task automatic idle(input int n, input logic e);
      for (int i = 0; i < n; i++) step(1'b0, 12'h000, 1'b0, e);
   endtask

   // Monitor: every post-reset edge produces one output word to compare
   initial begin
      logic [10:0] exp_w;
      forever begin
         @(posedge clk);
         #1;
         if (reset_n && exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            check("an",   {5'b0, an}, {5'b0, exp_w[10:8]});
            check("sseg", sseg,       exp_w[7:0]);
         end
      end
   end

   initial begin
      logic [11:0] rb;
      int          guard;
      reset_n = 1'b0; load = 1'b0; bcd = 12'h000; ovf = 1'b0; disp_en = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_an",   {5'b0, an}, 8'h07);
      check("reset_sseg", sseg,       8'hFF);

      @(negedge clk);
      reset_n = 1'b1;
      edges = 0; snap_m = 12'h000; ovf_m = 1'b0;
      apply(1'b0, 12'h000, 1'b0, 1'b1);

      idle(2, 1'b1);
      step(1'b1, 12'h123, 1'b0, 1'b1);
      idle(14, 1'b1);
      step(1'b1, 12'h000, 1'b1, 1'b1);
      idle(13, 1'b1);
      step(1'b1, 12'h007, 1'b0, 1'b1);
      idle(13, 1'b1);
      step(1'b1, 12'h000, 1'b1, 1'b1);
      idle(13, 1'b1);

      idle(1, 1'b1);
      idle(3, 1'b0);
      idle(9, 1'b1);

      step(1'b1, 12'h9A9, 1'b0, 1'b1);
      guard = 0;
      while (!(((edges / RC) % 3) == 2 && (edges % RC) == 2) && guard < 50) begin
         idle(1, 1'b1);
         guard++;
      end
      check("reach_dig2", 8'(guard < 50), 8'h01);
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check("midreset_an",   {5'b0, an}, 8'h07);
      check("midreset_sseg", sseg,       8'hFF);
      exp_q.delete();
      repeat (2) @(negedge clk);
      check("held_reset_sseg", sseg, 8'hFF);
      reset_n = 1'b1;
      edges = 0; snap_m = 12'h000; ovf_m = 1'b0;
      apply(1'b0, 12'h000, 1'b0, 1'b1);
      idle(12, 1'b1);

      for (int i = 0; i < 400; i++) begin
         rb = 12'($urandom);
         if ($urandom_range(0, 2) == 0) rb[11:8] = 4'h0;
         if ($urandom_range(0, 3) == 0) rb[7:4]  = 4'h0;
         step(($urandom_range(0, 3) == 0), rb, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) != 0));
      end
      idle(1, 1'b1);

      @(negedge clk);
      check("queue_drained", 8'(exp_q.size()), 8'h00);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
